multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Brief    : Multicycle MIPS-subset control FSM with a memory handshake and wait timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_control #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       IllegalOp,
  output logic       MemTimeout,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    ST_RST       = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_READ  = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WRITE = 4'd6,
    ST_EXEC_R    = 4'd7,
    ST_R_WB      = 4'd8,
    ST_EXEC_I    = 4'd9,
    ST_I_WB      = 4'd10,
    ST_BRANCH    = 4'd11,
    ST_JUMP      = 4'd12
  } state_t;

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_ORI   = 6'b001101;
  localparam logic [5:0] C_OP_ANDI  = 6'b001100;
  localparam logic [5:0] C_OP_LUI   = 6'b001111;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_BNE   = 6'b000101;
  localparam logic [5:0] C_OP_J     = 6'b000010;

  // Counter only needs to reach WAIT_LIMIT-1: the WAIT_LIMIT-th idle cycle aborts.
  localparam int             C_CW        = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);
  localparam logic [C_CW-1:0] C_WAIT_LAST = C_CW'(WAIT_LIMIT - 1);

  state_t          r_state;
  state_t          w_next;
  logic [5:0]      r_op;
  logic [C_CW-1:0] r_wait_cnt;
  logic            r_timeout;
  logic            w_wait_state;
  logic            w_timeout;

  assign w_wait_state = (r_state == ST_FETCH) || (r_state == ST_MEM_READ) ||
                        (r_state == ST_MEM_WRITE);
  assign w_timeout    = w_wait_state && !MemReady && (r_wait_cnt == C_WAIT_LAST);
  assign MemTimeout   = r_timeout;
  assign State        = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RST;
      r_op       <= 6'd0;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_timeout <= w_timeout;
      if (r_state == ST_DECODE) r_op <= Opcode;
      if (w_wait_state && !MemReady && !w_timeout) r_wait_cnt <= r_wait_cnt + C_CW'(1);
      else                                         r_wait_cnt <= '0;
    end
  end

  always_comb begin
    w_next    = r_state;
    PCWrite   = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    MemtoReg  = 1'b0;
    ALUSrcA   = 1'b0;
    RegWrite  = 1'b0;
    RegDst    = 1'b0;
    IllegalOp = 1'b0;
    PCSource  = 2'b00;
    ALUOp     = 3'b000;
    ALUSrcB   = 2'b00;
    case (r_state)
      ST_RST: w_next = ST_FETCH;
      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = 3'b110;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          w_next  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ALUSrcB = 2'b11;
        ALUOp   = 3'b110;
        case (Opcode)
          C_OP_RTYPE:                               w_next = ST_EXEC_R;
          C_OP_ADDI, C_OP_ORI, C_OP_ANDI, C_OP_LUI: w_next = ST_EXEC_I;
          C_OP_LW, C_OP_SW:                         w_next = ST_MEM_ADDR;
          C_OP_BEQ, C_OP_BNE:                       w_next = ST_BRANCH;
          C_OP_J:                                   w_next = ST_JUMP;
          default: begin
            IllegalOp = 1'b1;
            w_next    = ST_FETCH;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 3'b110;
        w_next  = (r_op == C_OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      end
      ST_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady)       w_next = ST_MEM_WB;
        else if (w_timeout) w_next = ST_FETCH;
      end
      ST_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        w_next   = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady || w_timeout) w_next = ST_FETCH;
      end
      ST_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b111;
        w_next  = ST_R_WB;
      end
      ST_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        w_next   = ST_FETCH;
      end
      ST_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (r_op)
          C_OP_ORI:  ALUOp = 3'b101;
          C_OP_ANDI: ALUOp = 3'b100;
          C_OP_LUI:  ALUOp = 3'b011;
          default:   ALUOp = 3'b110;
        endcase
        w_next = ST_I_WB;
      end
      ST_I_WB: begin
        RegWrite = 1'b1;
        w_next   = ST_FETCH;
      end
      ST_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 3'b010;
        PCSource = 2'b01;
        PCWrite  = (r_op == C_OP_BNE) ? ~Zero : Zero;
        w_next   = ST_FETCH;
      end
      ST_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        w_next   = ST_FETCH;
      end
      default: w_next = ST_RST;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Directed self-checking bench for multicycle_control.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] Opcode;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA;
  logic       RegWrite, RegDst, IllegalOp, MemTimeout;
  logic [1:0] PCSource;
  logic [2:0] ALUOp;
  logic [1:0] ALUSrcB;
  logic [3:0] State;

  int total = 0;
  int bad   = 0;

  multicycle_control #(.WAIT_LIMIT(15)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .IllegalOp(IllegalOp), .MemTimeout(MemTimeout),
    .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {State, PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA,
  //  RegWrite, RegDst, IllegalOp, MemTimeout, PCSource, ALUOp, ALUSrcB}
  wire [21:0] obs = {State, PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA,
                     RegWrite, RegDst, IllegalOp, MemTimeout, PCSource, ALUOp, ALUSrcB};

  localparam logic [17:0] C_FR  = 18'b1_0_1_0_1_0_0_0_0_0_0_00_110_01;
  localparam logic [17:0] C_FN  = 18'b0_0_1_0_0_0_0_0_0_0_0_00_110_01;
  localparam logic [17:0] C_TO  = 18'b0_0_0_0_0_0_0_0_0_0_1_00_000_00;
  localparam logic [17:0] C_DEC = 18'b0_0_0_0_0_0_0_0_0_0_0_00_110_11;
  localparam logic [17:0] C_ILL = 18'b0_0_0_0_0_0_0_0_0_1_0_00_110_11;
  localparam logic [17:0] C_MA  = 18'b0_0_0_0_0_0_1_0_0_0_0_00_110_10;
  localparam logic [17:0] C_MR  = 18'b0_1_1_0_0_0_0_0_0_0_0_00_000_00;
  localparam logic [17:0] C_MWB = 18'b0_0_0_0_0_1_0_1_0_0_0_00_000_00;
  localparam logic [17:0] C_MW  = 18'b0_1_0_1_0_0_0_0_0_0_0_00_000_00;
  localparam logic [17:0] C_EXR = 18'b0_0_0_0_0_0_1_0_0_0_0_00_111_00;
  localparam logic [17:0] C_RWB = 18'b0_0_0_0_0_0_0_1_1_0_0_00_000_00;
  localparam logic [17:0] C_EXI = 18'b0_0_0_0_0_0_1_0_0_0_0_00_000_10;
  localparam logic [17:0] C_IWB = 18'b0_0_0_0_0_0_0_1_0_0_0_00_000_00;
  localparam logic [17:0] C_BR0 = 18'b0_0_0_0_0_0_1_0_0_0_0_01_010_00;
  localparam logic [17:0] C_BR1 = 18'b1_0_0_0_0_0_1_0_0_0_0_01_010_00;
  localparam logic [17:0] C_JMP = 18'b1_0_0_0_0_0_0_0_0_0_0_10_000_00;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; MemReady = 1'b1; Opcode = 6'd0; Zero = 1'b0;
    cyc(); cyc();
    #1;
    total++;
    if (obs !== 22'd0) begin
      bad++; $display("FAIL reset_state: got %h want %h", obs, 22'd0);
    end
    reset = 1'b0;
    cyc();
    #1;
    total++;
    if (obs !== {4'd1, C_FR}) begin
      bad++; $display("FAIL reset_first_fetch: got %h want %h", obs, {4'd1, C_FR});
    end
  endtask

  task automatic test_rtype();
    logic [21:0] exp [0:4];
    exp = '{{4'd1, C_FR}, {4'd2, C_DEC}, {4'd7, C_EXR}, {4'd8, C_RWB}, {4'd1, C_FR}};
    Opcode = 6'b000000; MemReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (obs !== exp[i]) begin
        bad++; $display("FAIL add_step%0d: got %h want %h", i, obs, exp[i]);
      end
      if (i < 4) cyc();
    end
  endtask

  task automatic test_load_stall();
    logic [21:0] exp [0:8];
    logic        rdy [0:8];
    exp = '{{4'd1, C_FR}, {4'd2, C_DEC}, {4'd3, C_MA}, {4'd4, C_MR}, {4'd4, C_MR},
            {4'd4, C_MR}, {4'd4, C_MR}, {4'd5, C_MWB}, {4'd1, C_FR}};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    Opcode = 6'b100011;
    for (int i = 0; i < 9; i++) begin
      MemReady = rdy[i];
      #1;
      total++;
      if (obs !== exp[i]) begin
        bad++; $display("FAIL lw_step%0d: got %h want %h", i, obs, exp[i]);
      end
      if (i < 8) cyc();
    end
  endtask

  task automatic test_store();
    logic [21:0] exp [0:4];
    exp = '{{4'd1, C_FR}, {4'd2, C_DEC}, {4'd3, C_MA}, {4'd6, C_MW}, {4'd1, C_FR}};
    Opcode = 6'b101011; MemReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (obs !== exp[i]) begin
        bad++; $display("FAIL sw_step%0d: got %h want %h", i, obs, exp[i]);
      end
      if (i < 4) cyc();
    end
  endtask

  task automatic test_branch();
    logic [21:0] exp [0:7];
    logic [5:0]  opc [0:7];
    exp = '{{4'd1, C_FR}, {4'd2, C_DEC}, {4'd11, C_BR1}, {4'd1, C_FR},
            {4'd1, C_FR}, {4'd2, C_DEC}, {4'd11, C_BR0}, {4'd1, C_FR}};
    opc = '{6'b000100, 6'b000100, 6'b000100, 6'b000101,
            6'b000101, 6'b000101, 6'b000101, 6'b000101};
    Zero = 1'b1; MemReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      Opcode = opc[i];
      #1;
      total++;
      if (obs !== exp[i]) begin
        bad++; $display("FAIL branch_step%0d: got %h want %h", i, obs, exp[i]);
      end
      if (i != 3 && i < 7) cyc();
    end
    Zero = 1'b0;
  endtask

  task automatic test_imm();
    logic [5:0]  opc [0:3];
    logic [2:0]  aop [0:3];
    logic [21:0] exp;
    opc = '{6'b001101, 6'b001100, 6'b001111, 6'b001000};
    aop = '{3'b101, 3'b100, 3'b011, 3'b110};
    MemReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      Opcode = opc[k];
      for (int i = 0; i < 5; i++) begin
        case (i)
          0, 4:    exp = {4'd1, C_FR};
          1:       exp = {4'd2, C_DEC};
          2:       exp = {4'd9, C_EXI | {13'd0, aop[k], 2'b00}};
          default: exp = {4'd10, C_IWB};
        endcase
        #1;
        total++;
        if (obs !== exp) begin
          bad++; $display("FAIL imm%0d_step%0d: got %h want %h", k, i, obs, exp);
        end
        if (i < 4) cyc();
      end
    end
  endtask

  task automatic test_jump();
    logic [21:0] exp [0:3];
    exp = '{{4'd1, C_FR}, {4'd2, C_DEC}, {4'd12, C_JMP}, {4'd1, C_FR}};
    Opcode = 6'b000010; MemReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (obs !== exp[i]) begin
        bad++; $display("FAIL jump_step%0d: got %h want %h", i, obs, exp[i]);
      end
      if (i < 3) cyc();
    end
  endtask

  task automatic test_illegal();
    logic [21:0] exp [0:2];
    exp = '{{4'd1, C_FR}, {4'd2, C_ILL}, {4'd1, C_FR}};
    Opcode = 6'b111111; MemReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (obs !== exp[i]) begin
        bad++; $display("FAIL illegal_step%0d: got %h want %h", i, obs, exp[i]);
      end
      if (i < 2) cyc();
    end
  endtask

  task automatic test_timeout();
    logic [21:0] exp;
    Opcode = 6'b000000; MemReady = 1'b0;
    for (int i = 0; i < 17; i++) begin
      exp = (i == 15) ? {4'd1, C_FN | C_TO} : {4'd1, C_FN};
      #1;
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL timeout_cycle%0d: got %h want %h", i, obs, exp);
      end
      cyc();
    end
    MemReady = 1'b1;
    #1;
    total++;
    if (obs !== {4'd1, C_FR}) begin
      bad++; $display("FAIL timeout_recover: got %h want %h", obs, {4'd1, C_FR});
    end
  endtask

  task automatic test_reset_mid_write();
    logic [21:0] exp [0:3];
    exp = '{{4'd1, C_FR}, {4'd2, C_DEC}, {4'd3, C_MA}, {4'd6, C_MW}};
    Opcode = 6'b101011;
    for (int i = 0; i < 4; i++) begin
      MemReady = (i < 3);
      #1;
      total++;
      if (obs !== exp[i]) begin
        bad++; $display("FAIL midrst_step%0d: got %h want %h", i, obs, exp[i]);
      end
      cyc();
    end
    #1;
    total++;
    if (obs !== {4'd6, C_MW}) begin
      bad++; $display("FAIL midrst_hold: got %h want %h", obs, {4'd6, C_MW});
    end
    reset = 1'b1;
    cyc();
    #1;
    total++;
    if (obs !== 22'd0) begin
      bad++; $display("FAIL midrst_reset: got %h want %h", obs, 22'd0);
    end
    reset = 1'b0; MemReady = 1'b1;
    cyc();
    #1;
    total++;
    if (obs !== {4'd1, C_FR}) begin
      bad++; $display("FAIL midrst_refetch: got %h want %h", obs, {4'd1, C_FR});
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_stall();
    test_store();
    test_branch();
    test_imm();
    test_jump();
    test_illegal();
    test_timeout();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
